// File: rtl/prog_updown_counter.sv
// Programmable up/down counter with modulus, load, one-shot mode and terminal-count pulse.
// Define CNT_PRESCALE_EN to add a psc_div-controlled step prescaler.
module prog_updown_counter #(
  parameter int unsigned      WIDTH   = 8,
  parameter logic [WIDTH-1:0] MAX_VAL = {WIDTH{1'b1}},
  parameter logic [WIDTH-1:0] RST_VAL = MAX_VAL
`ifdef CNT_PRESCALE_EN
  ,
  parameter int unsigned      PSC_WIDTH = 4
`endif
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             up_dn,
  input  logic             mode,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
`ifdef CNT_PRESCALE_EN
  input  logic [PSC_WIDTH-1:0] psc_div,
`endif
  output logic [WIDTH-1:0] count,
  output logic             tc,
  output logic             done
);

  logic [WIDTH-1:0] r_count;
  logic             r_tc;
  logic             r_done;

  logic [WIDTH-1:0] w_count_nxt;
  logic             w_tc_nxt;
  logic             w_done_nxt;
  logic             w_qual;
  logic             w_step;
  logic             w_at_term;

  // Cycles that may advance the counter, before any prescaling
  assign w_qual = en & ~load & ~r_done;

`ifdef CNT_PRESCALE_EN
  logic [PSC_WIDTH-1:0] r_psc;
  logic                 w_tick;

  assign w_tick = (r_psc == psc_div);
  assign w_step = w_qual & w_tick;

  // Phase is kept across en=0 / done=1 gaps and cleared by load or a tick
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_psc <= '0;
    end else if (load) begin
      r_psc <= '0;
    end else if (w_qual) begin
      r_psc <= w_tick ? '0 : r_psc + PSC_WIDTH'(1);
    end
  end
`else
  assign w_step = w_qual;
`endif

  assign w_at_term = up_dn ? (r_count == MAX_VAL) : (r_count == '0);

  // Next count / flags: load beats step beats hold
  always_comb begin
    w_count_nxt = r_count;
    w_tc_nxt    = 1'b0;
    w_done_nxt  = r_done;
    if (load) begin
      w_count_nxt = (load_val > MAX_VAL) ? MAX_VAL : load_val;
      w_done_nxt  = 1'b0;
    end else if (w_step) begin
      if (w_at_term) begin
        w_tc_nxt = 1'b1;
        if (mode) begin
          w_done_nxt = 1'b1;
        end else begin
          w_count_nxt = up_dn ? '0 : MAX_VAL;
        end
      end else begin
        w_count_nxt = up_dn ? r_count + WIDTH'(1) : r_count - WIDTH'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_count <= RST_VAL;
      r_tc    <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_count <= w_count_nxt;
      r_tc    <= w_tc_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign count = r_count;
  assign tc    = r_tc;
  assign done  = r_done;

endmodule

// File: tb/tb_prog_updown_counter.sv
// Scoreboard bench for prog_updown_counter: u_a is 4-bit full range, u_b is 4-bit modulo-10.
// Prescaler vectors run only when CNT_PRESCALE_EN is defined.
module tb_prog_updown_counter;

  typedef struct {
    int          dut;
    logic [3:0]  cnt;
    logic        tc;
    logic        done;
    string       name;
  } exp_t;

  logic       clk;
  logic       rst;
  logic       a_en, b_en, a_load, b_load;
  logic       up_dn, mode;
  logic [3:0] load_val;
  logic [3:0] a_count, b_count;
  logic       a_tc, b_tc, a_done, b_done;
`ifdef CNT_PRESCALE_EN
  logic [3:0] psc_div;
`endif

  exp_t sb[$];
  event mon_ev;
  int   checks = 0;
  int   errors = 0;

  prog_updown_counter #(.WIDTH(4)) u_a (
    .clk(clk), .rst(rst), .en(a_en), .up_dn(up_dn), .mode(mode),
    .load(a_load), .load_val(load_val),
`ifdef CNT_PRESCALE_EN
    .psc_div(psc_div),
`endif
    .count(a_count), .tc(a_tc), .done(a_done)
  );

  prog_updown_counter #(.WIDTH(4), .MAX_VAL(4'd9)) u_b (
    .clk(clk), .rst(rst), .en(b_en), .up_dn(up_dn), .mode(mode),
    .load(b_load), .load_val(load_val),
`ifdef CNT_PRESCALE_EN
    .psc_div(psc_div),
`endif
    .count(b_count), .tc(b_tc), .done(b_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Monitor: drains every expectation queued for the edge (or async event) just seen
  initial begin
    exp_t       e;
    logic [3:0] gc;
    logic       gt, gd;
    forever begin
      @(posedge clk or mon_ev);
      #1;
      while (sb.size() > 0) begin
        e  = sb.pop_front();
        gc = (e.dut == 0) ? a_count : b_count;
        gt = (e.dut == 0) ? a_tc    : b_tc;
        gd = (e.dut == 0) ? a_done  : b_done;
        checks++;
        if (gc !== e.cnt || gt !== e.tc || gd !== e.done) begin
          errors++;
          $display("FAIL %s dut%0d got count=%0d tc=%b done=%b want count=%0d tc=%b done=%b",
                   e.name, e.dut, gc, gt, gd, e.cnt, e.tc, e.done);
        end
      end
    end
  end

  task automatic expect_v(input int s, input logic [3:0] c, input logic t, input logic d,
                          input string nm);
    exp_t e;
    e.dut = s; e.cnt = c; e.tc = t; e.done = d; e.name = nm;
    sb.push_back(e);
  endtask

  // One clock of stimulus on DUT s; the other DUT is held idle
  task automatic cyc(input int s, input logic e, input logic u, input logic m, input logic l,
                     input logic [3:0] lv, input logic [3:0] ec, input logic et,
                     input logic ed, input string nm);
    @(negedge clk);
    a_en     = (s == 0) ? e : 1'b0;
    a_load   = (s == 0) ? l : 1'b0;
    b_en     = (s == 1) ? e : 1'b0;
    b_load   = (s == 1) ? l : 1'b0;
    up_dn    = u;
    mode     = m;
    load_val = lv;
    expect_v(s, ec, et, ed, nm);
    @(posedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog timeout checks=%0d", checks);
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b0; a_en = 0; b_en = 0; a_load = 0; b_load = 0;
    up_dn = 0; mode = 0; load_val = 0;
`ifdef CNT_PRESCALE_EN
    psc_div = 4'd0;
`endif
    repeat (2) @(negedge clk);
    #1;
    expect_v(0, 4'd15, 1'b0, 1'b0, "reset_a");
    expect_v(1, 4'd9,  1'b0, 1'b0, "reset_b");
    -> mon_ev;
    @(negedge clk);
    rst = 1'b1;

    // Free-running down wrap on the full 0..15 range
    for (int i = 14; i >= 0; i--) cyc(0, 1, 0, 0, 0, 4'd0, 4'(i), 1'b0, 1'b0, "down_a");
    cyc(0, 1, 0, 0, 0, 4'd0, 4'd15, 1'b1, 1'b0, "down_wrap_a");
    for (int i = 14; i >= 7; i--) cyc(0, 1, 0, 0, 0, 4'd0, 4'(i), 1'b0, 1'b0, "down2_a");

    // Asynchronous reset mid-count, checked between clock edges
    @(negedge clk);
    #1 rst = 1'b0;
    #1;
    expect_v(0, 4'd15, 1'b0, 1'b0, "async_rst_a");
    expect_v(1, 4'd9,  1'b0, 1'b0, "async_rst_b");
    -> mon_ev;
    @(negedge clk);
    rst = 1'b1;

    // Modulo-10 up wrap
    cyc(1, 0, 1, 0, 1, 4'd0, 4'd0, 1'b0, 1'b0, "load0_b");
    for (int i = 1; i <= 9; i++) cyc(1, 1, 1, 0, 0, 4'd0, 4'(i), 1'b0, 1'b0, "up_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd0, 1'b1, 1'b0, "up_wrap_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd1, 1'b0, 1'b0, "up_after_wrap_b");

    // One-shot down, then reload clears done
    cyc(0, 1, 0, 1, 1, 4'd3, 4'd3, 1'b0, 1'b0, "load3_a");
    cyc(0, 1, 0, 1, 0, 4'd0, 4'd2, 1'b0, 1'b0, "os_a");
    cyc(0, 1, 0, 1, 0, 4'd0, 4'd1, 1'b0, 1'b0, "os_a");
    cyc(0, 1, 0, 1, 0, 4'd0, 4'd0, 1'b0, 1'b0, "os_a");
    cyc(0, 1, 0, 1, 0, 4'd0, 4'd0, 1'b1, 1'b1, "os_term_a");
    for (int i = 0; i < 5; i++) cyc(0, 1, 0, 1, 0, 4'd0, 4'd0, 1'b0, 1'b1, "os_hold_a");
    cyc(0, 1, 0, 1, 1, 4'd5, 4'd5, 1'b0, 1'b0, "reload5_a");
    cyc(0, 1, 0, 1, 0, 4'd0, 4'd4, 1'b0, 1'b0, "resume_a");

    // Load beats enable and clamps to MAX_VAL
    cyc(1, 1, 1, 0, 1, 4'd12, 4'd9, 1'b0, 1'b0, "load_clamp_b");
    for (int i = 0; i < 3; i++) cyc(1, 0, 1, 0, 0, 4'd0, 4'd9, 1'b0, 1'b0, "en_off_b");
    cyc(1, 1, 1, 1, 0, 4'd0, 4'd9, 1'b1, 1'b1, "os_up_term_b");
    cyc(1, 1, 1, 1, 0, 4'd0, 4'd9, 1'b0, 1'b1, "os_up_hold_b");

    // Direction reversal and down wrap to MAX_VAL
    cyc(1, 0, 1, 0, 1, 4'd5, 4'd5, 1'b0, 1'b0, "load5_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd6, 1'b0, 1'b0, "rev_up_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd7, 1'b0, 1'b0, "rev_up_b");
    for (int i = 6; i >= 0; i--) cyc(1, 1, 0, 0, 0, 4'd0, 4'(i), 1'b0, 1'b0, "rev_dn_b");
    cyc(1, 1, 0, 0, 0, 4'd0, 4'd9, 1'b1, 1'b0, "dn_wrap_b");
    cyc(1, 1, 0, 0, 0, 4'd0, 4'd8, 1'b0, 1'b0, "dn_after_wrap_b");

`ifdef CNT_PRESCALE_EN
    // Divide-by-3 stepping, phase held through en=0, cleared by load
    psc_div = 4'd2;
    cyc(1, 0, 1, 0, 1, 4'd0, 4'd0, 1'b0, 1'b0, "psc_load_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0, "psc_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0, "psc_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd1, 1'b0, 1'b0, "psc_tick_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd1, 1'b0, 1'b0, "psc_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd1, 1'b0, 1'b0, "psc_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd2, 1'b0, 1'b0, "psc_tick_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd2, 1'b0, 1'b0, "psc_b");
    cyc(1, 0, 1, 0, 0, 4'd0, 4'd2, 1'b0, 1'b0, "psc_gap_b");
    cyc(1, 0, 1, 0, 0, 4'd0, 4'd2, 1'b0, 1'b0, "psc_gap_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd2, 1'b0, 1'b0, "psc_phase_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd3, 1'b0, 1'b0, "psc_phase_tick_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd3, 1'b0, 1'b0, "psc_b");
    cyc(1, 1, 1, 0, 1, 4'd0, 4'd0, 1'b0, 1'b0, "psc_reload_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0, "psc_clr_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd0, 1'b0, 1'b0, "psc_clr_b");
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd1, 1'b0, 1'b0, "psc_clr_tick_b");
    psc_div = 4'd0;
    cyc(1, 1, 1, 0, 0, 4'd0, 4'd2, 1'b0, 1'b0, "psc0_b");
`endif

    @(negedge clk);
    a_en = 0; b_en = 0; a_load = 0; b_load = 0;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain got %0d pending want 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
